wb_uart_tx: RTL
===============

Name: wb_uart_tx

Overview:
- Wishbone classic slave UART transmitter for the compute tile.
- Driven directly by the network adapter's Wishbone master, so NoC-originated register writes become serial output.
- Buffers bytes in a FIFO and serializes them as 8N1, LSB first, with a programmable baud divisor.
- Provides status readback and a TX-empty interrupt.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, minimum 2.
- DIV_RESET, 868, reset value of the baud divisor (clk cycles per bit; 100 MHz / 115200).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wb_adr_i  in  32  byte address; only [3:2] decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables; ignored (full-word access)
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error
- tx_o  out  1  serial output; idle high
- irq_o  out  1  TX-empty interrupt, level

Behaviour:
- Reset values (asynchronous, active-high):
  - tx_o=1, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, irq_o=0.
  - FIFO empty, serializer IDLE.
  - CTRL=0x1 (enable=1, irq_en=0), DIV=DIV_RESET.
- Register map (adr[3:2]):
  - 0 TXDATA: write pushes dat_i[7:0]; reads return 0.
  - 1 STATUS (RO): bit0 busy (serializer not IDLE), bit1 full, bit2 empty, bits[15:8] FIFO level; other bits 0. Writes are acked and ignored.
  - 2 CTRL: bit0 enable, bit1 flush (self-clearing, write-only, reads 0), bit2 irq_en.
  - 3 DIV: bits[15:0] divisor; reads return the stored value.
- Wishbone handshake:
  - Response is registered: ack/err rises on the edge after cyc&stb are sampled high with ack=0 and err=0.
  - Response is a single-cycle pulse; the next response comes no earlier than 2 cycles later.
  - Exactly one of ack/err per transfer.
  - wb_dat_o is valid while ack=1; it is 0 otherwise.
  - Register side effects (push, CTRL/DIV update) occur on the same edge ack/err rises.
- TXDATA write with FIFO full:
  - err=1 instead of ack; byte dropped; FIFO unchanged.
  - This holds even if the serializer pops in the same cycle.
- Flush:
  - Empties the FIFO on the write edge.
  - A frame already in progress completes.
  - If the flush write is also a push, it is a CTRL write, so no push occurs.
- Serializer states: IDLE, START, DATA, STOP.
  - IDLE: if enable & !empty, pop the FIFO head into the shift register, latch the effective divisor, go to START. tx_o=1.
  - START: tx_o=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each. A 3-bit counter wraps 7→0, then go to STOP.
  - STOP: tx_o=1 for DIV cycles, then IDLE. Next frame may start on the following cycle, so back-to-back frames are 10*DIV+1 cycles apart.
  - tx_o is driven from a register.
- Latency: with FIFO empty and serializer IDLE, tx_o falls 2 cycles after ack rises (push edge, then pop edge).
- Baud counter: counts down latched_div-1..0 per bit. Effective divisor = max(DIV,2).
- DIV writes mid-frame take effect at the next frame start.
- Clearing enable mid-frame lets the current frame complete; no further pops occur.
- irq_o (registered) = irq_en & empty & (state==IDLE).
- FIFO: level counter is FIFO_DEPTH+1 states wide. Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame: tx_o returns to 1 immediately; FIFO contents are discarded.

Decomposition:
- Shared package uart_tx_pkg holds:
  - Register index constants (REG_TXDATA=0, REG_STATUS=1, REG_CTRL=2, REG_DIV=3).
  - STATUS/CTRL bit positions.
  - Serializer state enum.
- Sub-module uart_tx_fifo (synchronous FIFO: push/pop/flush, full/empty/level, same reset) is instantiated once.

Test Plan:
- Setup for all tests: DIV=4. Write TXDATA=0xA5 → ack after 1 cycle; tx_o falls 2 cycles after ack. Observed bits over 40 cycles are 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB-first, stop).
- Full FIFO: with enable=0, push 16 bytes, all acked → STATUS reads 0x1002. 17th write gets err=1, ack=0. Set enable=1 → exactly 16 frames are emitted, in order.
- Flush mid-frame: 3 bytes queued, first frame in progress. Write CTRL=0x3 → STATUS.empty=1 on the next read. The current frame completes; no further start bits.
- DIV edge case: write DIV=0 → bit period of 2 cycles. Write DIV=8 during a frame → the current frame keeps its old period; the next frame uses 8.
- IRQ: CTRL=0x5, one byte pushed → irq_o=0 while busy; irq_o=1 one cycle after STOP ends. Write CTRL=0x1 → irq_o=0.
- Async reset: assert rst mid-DATA → tx_o=1 and all outputs at their reset values without a clock edge. After deassertion, STATUS reads 0x0004.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the Wishbone UART transmitter:
// register indices, STATUS/CTRL bit positions, serializer states.
package uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_LVL_LSB = 8;

  localparam int CT_EN    = 0;
  localparam int CT_FLUSH = 1;
  localparam int CT_IRQEN = 2;

  typedef logic [1:0] ser_state_t;

  localparam ser_state_t S_IDLE  = 2'd0;
  localparam ser_state_t S_START = 2'd1;
  localparam ser_state_t S_DATA  = 2'd2;
  localparam ser_state_t S_STOP  = 2'd3;

  // A divisor below 2 is clamped so every bit lasts at least 2 cycles.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with flush; flush overrides push/pop.
// Ports: push_i/data_i, pop_i/data_o (head), flush_i, full_o, empty_o, level_o.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [7:0]                 data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [7:0]                 data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      lvl_d = lvl_q + {{AW{1'b0}}, push_i}
                    - {{AW{1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (lvl_q == (AW+1)'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone classic slave UART transmitter (8N1, LSB first).
// Ports: wb_* slave bus, tx_o serial line (idle high), irq_o TX-empty level irq.
module wb_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic        ack_q, err_q;
  logic [31:0] dat_q, rdata;
  logic        en_q, irqen_q;
  logic [15:0] div_q;
  ser_state_t  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] divl_q, divl_d;
  logic        tx_q, tx_d;
  logic        irq_q;

  logic        req, wr, push, wr_err, flush, pop;
  logic        full, empty, busy;
  logic [7:0]  head;
  logic [AW:0] level;
  logic [1:0]  idx;
  logic        unused_ok;

  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4],
                       wb_adr_i[1:0], wb_dat_i[31:16]};

  assign idx    = wb_adr_i[3:2];
  // One response per transfer; the held strobe is not re-sampled
  // while the previous response is still showing.
  assign req    = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign wr     = req & wb_we_i;
  assign wr_err = wr & (idx == REG_TXDATA) & full;
  assign push   = wr & (idx == REG_TXDATA) & ~full;
  assign flush  = wr & (idx == REG_CTRL) & wb_dat_i[CT_FLUSH];
  assign busy   = (state_q != S_IDLE);
  assign pop    = ~busy & en_q & ~empty & ~flush;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (wb_dat_i[7:0]),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    rdata = '0;
    case (idx)
      REG_STATUS: begin
        rdata[ST_BUSY]  = busy;
        rdata[ST_FULL]  = full;
        rdata[ST_EMPTY] = empty;
        rdata[ST_LVL_LSB +: AW+1] = level;
      end
      REG_CTRL: begin
        rdata[CT_EN]    = en_q;
        rdata[CT_IRQEN] = irqen_q;
      end
      REG_DIV: rdata[15:0] = div_q;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      en_q    <= 1'b1;
      irqen_q <= 1'b0;
      div_q   <= 16'(DIV_RESET);
    end else begin
      ack_q <= req & ~wr_err;
      err_q <= wr_err;
      dat_q <= (req & ~wb_we_i) ? rdata : '0;
      if (wr && idx == REG_CTRL) begin
        en_q    <= wb_dat_i[CT_EN];
        irqen_q <= wb_dat_i[CT_IRQEN];
      end
      if (wr && idx == REG_DIV) div_q <= wb_dat_i[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    baud_d  = baud_q;
    divl_d  = divl_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = head;
          divl_d  = eff_div(div_q);
          baud_d  = eff_div(div_q) - 16'd1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = divl_q - 16'd1;
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d  = divl_q - 16'd1;
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_q == '0) state_d = S_IDLE;
        else              baud_d  = baud_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level follows the registered state one cycle later,
  // so every bit keeps its full duration.
  always_comb begin
    tx_d = 1'b1;
    if (state_q == S_START)     tx_d = 1'b0;
    else if (state_q == S_DATA) tx_d = shift_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      baud_q  <= '0;
      divl_q  <= 16'd2;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      baud_q  <= baud_d;
      divl_q  <= divl_d;
      tx_q    <= tx_d;
      irq_q   <= irqen_q & empty & ~busy;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign tx_o     = tx_q;
  assign irq_o    = irq_q;

endmodule
